// File: rtl/axis_lfsr_checker.sv
// AXI-Stream sink that checks incoming 16-bit words against a Galois LFSR sequence.
// Reports mismatch count, first mismatch index and beat count; optional tready throttling.

module axis_lfsr_checker #(
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter logic [15:0] POLY        = 16'hB400,
    parameter bit          THROTTLE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] word_num,
    input  logic        s_axis_tvaild,
    output logic        s_axis_tready,
    input  logic [15:0] s_axis_tdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic [31:0] first_err_idx,
    output logic [31:0] rx_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] expected_q, expected_d;
    logic [1:0]  thr_cnt_q, thr_cnt_d;
    logic [31:0] word_num_q, word_num_d;
    logic [31:0] rx_cnt_q, rx_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [31:0] first_err_idx_q, first_err_idx_d;
    logic        pass_q, pass_d;
    logic        tready_q, tready_d;

    logic        handshake;
    logic        mismatch;
    logic [15:0] expected_next;

    assign handshake     = s_axis_tvaild && tready_q && (state_q == StCheck);
    assign mismatch      = (s_axis_tdata != expected_q);
    assign expected_next = {1'b0, expected_q[15:1]} ^ (expected_q[0] ? POLY : 16'h0000);

    always_comb begin
        state_d         = state_q;
        expected_d      = expected_q;
        thr_cnt_d       = thr_cnt_q;
        word_num_d      = word_num_q;
        rx_cnt_d        = rx_cnt_q;
        err_cnt_d       = err_cnt_q;
        first_err_idx_d = first_err_idx_q;
        pass_d          = pass_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    word_num_d      = word_num;
                    expected_d      = SEED;
                    rx_cnt_d        = 32'd0;
                    err_cnt_d       = 16'd0;
                    first_err_idx_d = 32'd0;
                    thr_cnt_d       = 2'd0;
                    if (word_num != 32'd0) begin
                        state_d = StCheck;
                        pass_d  = 1'b0;
                    end else begin
                        // Empty run: nothing to check, so it trivially passes.
                        state_d = StDone;
                        pass_d  = 1'b1;
                    end
                end
            end

            StCheck: begin
                thr_cnt_d = thr_cnt_q + 2'd1;
                if (handshake) begin
                    rx_cnt_d   = rx_cnt_q + 32'd1;
                    expected_d = expected_next;
                    if (mismatch) begin
                        if (err_cnt_q == 16'd0) begin
                            first_err_idx_d = rx_cnt_q;
                        end
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                    end
                    // Final beat: pass must see the error count including this beat.
                    if (rx_cnt_d == word_num_q) begin
                        state_d = StDone;
                        pass_d  = (err_cnt_d == 16'd0);
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // tready is computed from next-state values so the flop holds this cycle's decision.
    always_comb begin
        tready_d = (state_d == StCheck) && (!THROTTLE_EN || (thr_cnt_d != 2'd3));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            expected_q      <= SEED;
            thr_cnt_q       <= 2'd0;
            word_num_q      <= 32'd0;
            rx_cnt_q        <= 32'd0;
            err_cnt_q       <= 16'd0;
            first_err_idx_q <= 32'd0;
            pass_q          <= 1'b0;
            tready_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            expected_q      <= expected_d;
            thr_cnt_q       <= thr_cnt_d;
            word_num_q      <= word_num_d;
            rx_cnt_q        <= rx_cnt_d;
            err_cnt_q       <= err_cnt_d;
            first_err_idx_q <= first_err_idx_d;
            pass_q          <= pass_d;
            tready_q        <= tready_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign busy          = (state_q == StCheck);
    assign done          = (state_q == StDone);
    assign pass          = pass_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_idx_q;
    assign rx_cnt        = rx_cnt_q;

endmodule

// File: tb/tb_axis_lfsr_checker.sv
// Bench for axis_lfsr_checker: an unthrottled and a throttled instance share stimulus;
// per-beat expected status is queued on each driven handshake and compared one cycle later.

module tb_axis_lfsr_checker;

    localparam logic [15:0] SEED_C = 16'hACE1;
    localparam logic [15:0] POLY_C = 16'hB400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] word_num;
    logic        tvalid;
    logic [15:0] tdata;

    logic        tready_u, busy_u, done_u, pass_u;
    logic [15:0] err_u;
    logic [31:0] fidx_u, rx_u;
    logic        tready_t, busy_t, done_t, pass_t;
    logic [15:0] err_t;
    logic [31:0] fidx_t, rx_t;

    bit          thr_sel;
    logic        obs_rdy, obs_busy, obs_done, obs_pass;
    logic [15:0] obs_err;
    logic [31:0] obs_fidx, obs_rx;

    typedef struct packed {
        logic [31:0] rx;
        logic [15:0] err;
        logic [31:0] fidx;
        logic        done;
        logic        pass;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] stim_q[$];
    int          hs_log[$];
    bit          rdy_log[$];

    logic [15:0] m_exp;
    logic [31:0] m_rx, m_wn, m_fidx;
    logic [15:0] m_err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    axis_lfsr_checker #(
        .SEED        (SEED_C),
        .POLY        (POLY_C),
        .THROTTLE_EN (1'b0)
    ) dut_u (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .word_num      (word_num),
        .s_axis_tvaild (tvalid),
        .s_axis_tready (tready_u),
        .s_axis_tdata  (tdata),
        .busy          (busy_u),
        .done          (done_u),
        .pass          (pass_u),
        .err_cnt       (err_u),
        .first_err_idx (fidx_u),
        .rx_cnt        (rx_u)
    );

    axis_lfsr_checker #(
        .SEED        (SEED_C),
        .POLY        (POLY_C),
        .THROTTLE_EN (1'b1)
    ) dut_t (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .word_num      (word_num),
        .s_axis_tvaild (tvalid),
        .s_axis_tready (tready_t),
        .s_axis_tdata  (tdata),
        .busy          (busy_t),
        .done          (done_t),
        .pass          (pass_t),
        .err_cnt       (err_t),
        .first_err_idx (fidx_t),
        .rx_cnt        (rx_t)
    );

    assign obs_rdy  = thr_sel ? tready_t : tready_u;
    assign obs_busy = thr_sel ? busy_t : busy_u;
    assign obs_done = thr_sel ? done_t : done_u;
    assign obs_pass = thr_sel ? pass_t : pass_u;
    assign obs_err  = thr_sel ? err_t : err_u;
    assign obs_fidx = thr_sel ? fidx_t : fidx_u;
    assign obs_rx   = thr_sel ? rx_t : rx_u;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {1'b0, x[15:1]} ^ (x[0] ? POLY_C : 16'h0000);
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        tvalid   = 1'b0;
        tdata    = 16'h0000;
        word_num = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after start was taken.
    task automatic start_run(input logic [31:0] n);
        m_exp  = SEED_C;
        m_rx   = 32'd0;
        m_err  = 16'd0;
        m_fidx = 32'd0;
        m_wn   = n;
        sb.delete();
        stim_q.delete();
        word_num = n;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_stream(input int max_cyc);
        int          cyc;
        exp_t        e;
        logic [15:0] w;
        cyc = 0;
        hs_log.delete();
        rdy_log.delete();
        while ((stim_q.size() > 0 || sb.size() > 0) && cyc < max_cyc) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({obs_rx, obs_err, obs_fidx, obs_done, obs_pass} !==
                    {e.rx, e.err, e.fidx, e.done, e.pass}) begin
                    $display("FAIL beat_status @%0d: got rx=%0d err=%h fidx=%0d done=%b pass=%b, want rx=%0d err=%h fidx=%0d done=%b pass=%b",
                             cyc, obs_rx, obs_err, obs_fidx, obs_done, obs_pass,
                             e.rx, e.err, e.fidx, e.done, e.pass);
                end else begin
                    n_pass++;
                end
            end
            rdy_log.push_back(obs_rdy);
            if (stim_q.size() > 0) begin
                tvalid = 1'b1;
                tdata  = stim_q[0];
                if (obs_rdy === 1'b1) begin
                    hs_log.push_back(cyc);
                    w = stim_q.pop_front();
                    if (w != m_exp) begin
                        if (m_err == 16'd0) m_fidx = m_rx;
                        if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
                    end
                    m_rx  = m_rx + 32'd1;
                    m_exp = lfsr_step(m_exp);
                    e.rx   = m_rx;
                    e.err  = m_err;
                    e.fidx = m_fidx;
                    e.done = (m_rx == m_wn);
                    e.pass = (m_rx == m_wn) && (m_err == 16'd0);
                    sb.push_back(e);
                end
            end else begin
                tvalid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        tvalid = 1'b0;
        n_checks++;
        if (cyc >= max_cyc) begin
            $display("FAIL stream_timeout: got %0d cycles with %0d beats left, want drained within %0d",
                     cyc, stim_q.size(), max_cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset();
        thr_sel = 1'b0;
        rst_n   = 1'b0;
        start   = 1'b0;
        tvalid  = 1'b0;
        tdata   = 16'h0;
        word_num = 32'd0;
        #1;
        n_checks++;
        if ({tready_u, busy_u, done_u, pass_u, err_u, fidx_u, rx_u,
             tready_t, busy_t, done_t, pass_t, err_t, fidx_t, rx_t} !== '0) begin
            $display("FAIL reset_outputs: got u=%b%b%b%b %h %h %h t=%b%b%b%b, want all 0",
                     tready_u, busy_u, done_u, pass_u, err_u, fidx_u, rx_u,
                     tready_t, busy_t, done_t, pass_t);
        end else begin
            n_pass++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tvalid = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tready_u, busy_u, done_u, rx_u} !== '0) begin
            $display("FAIL idle_after_reset: got tready=%b busy=%b done=%b rx=%0d, want 0 0 0 0",
                     tready_u, busy_u, done_u, rx_u);
        end else begin
            n_pass++;
        end
        tvalid = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        thr_sel = 1'b0;
        start_run(32'd4);
        stim_q = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C};
        drive_stream(40);
        n_checks++;
        if (hs_log.size() != 4 || hs_log[0] != 0 || hs_log[3] != 3) begin
            $display("FAIL back_to_back: got %0d handshakes, want 4 on cycles 0..3", hs_log.size());
        end else begin
            n_pass++;
        end
        // DONE must hold its results and refuse data until the next start.
        tvalid = 1'b1;
        tdata  = 16'h1234;
        repeat (3) @(negedge clk);
        tvalid = 1'b0;
        n_checks++;
        if ({rx_u, err_u, pass_u, done_u, tready_u, busy_u} !== {32'd4, 16'd0, 4'b1100}) begin
            $display("FAIL done_hold: got rx=%0d err=%h pass=%b done=%b tready=%b busy=%b, want 4 0000 1 1 0 0",
                     rx_u, err_u, pass_u, done_u, tready_u, busy_u);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        thr_sel = 1'b0;
        start_run(32'd4);
        stim_q = '{16'hACE1, 16'hE270};
        drive_stream(40);
        // A start during CHECK must be ignored.
        word_num = 32'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stim_q = '{16'h0000, 16'h389C};
        drive_stream(40);
        n_checks++;
        if ({err_u, fidx_u, pass_u, done_u, rx_u} !== {16'd1, 32'd2, 2'b01, 32'd4}) begin
            $display("FAIL mismatch_result: got err=%0d fidx=%0d pass=%b done=%b rx=%0d, want 1 2 0 1 4",
                     err_u, fidx_u, pass_u, done_u, rx_u);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_throttle();
        logic [15:0] x;
        bit          pat[7];
        do_reset();
        thr_sel = 1'b1;
        start_run(32'd6);
        x = SEED_C;
        for (int i = 0; i < 6; i++) begin
            stim_q.push_back(x);
            x = lfsr_step(x);
        end
        drive_stream(40);
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (rdy_log.size() <= i || rdy_log[i] !== pat[i]) begin
                $display("FAIL tready_pattern[%0d]: got %b, want %b", i,
                         (rdy_log.size() > i) ? rdy_log[i] : 1'bx, pat[i]);
            end else begin
                n_pass++;
            end
        end
        n_checks++;
        if (hs_log.size() != 6 || hs_log[5] != 6) begin
            $display("FAIL throttle_handshakes: got %0d handshakes, last on cycle %0d, want 6 with last on cycle 6",
                     hs_log.size(), (hs_log.size() > 0) ? hs_log[hs_log.size()-1] : -1);
        end else begin
            n_pass++;
        end
        n_checks++;
        if ({tready_t, done_t, pass_t} !== 3'b011) begin
            $display("FAIL throttle_done: got tready=%b done=%b pass=%b, want 0 1 1",
                     tready_t, done_t, pass_t);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_zero_words();
        do_reset();
        thr_sel = 1'b0;
        start_run(32'd0);
        n_checks++;
        if ({done_u, pass_u, busy_u, rx_u, tready_u, tready_t, done_t} !== {3'b110, 32'd0, 3'b001}) begin
            $display("FAIL zero_words: got done=%b pass=%b busy=%b rx=%0d tready=%b/%b, want 1 1 0 0 0/0",
                     done_u, pass_u, busy_u, rx_u, tready_u, tready_t);
        end else begin
            n_pass++;
        end
        tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({tready_u, tready_t, rx_u} !== '0) begin
                $display("FAIL zero_words_tready[%0d]: got tready=%b/%b rx=%0d, want 0/0 0",
                         i, tready_u, tready_t, rx_u);
            end else begin
                n_pass++;
            end
        end
        tvalid = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        thr_sel = 1'b0;
        start_run(32'd8);
        stim_q = '{16'hACE1, 16'hE270};
        drive_stream(40);
        tvalid = 1'b1;
        tdata  = 16'h7138;
        rst_n  = 1'b0;
        #1;
        n_checks++;
        if ({tready_u, busy_u, done_u, pass_u, err_u, fidx_u, rx_u} !== '0) begin
            $display("FAIL mid_reset_outputs: got tready=%b busy=%b done=%b pass=%b err=%h fidx=%0d rx=%0d, want all 0",
                     tready_u, busy_u, done_u, pass_u, err_u, fidx_u, rx_u);
        end else begin
            n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tready_u, busy_u, done_u, rx_u} !== '0) begin
            $display("FAIL mid_reset_idle: got tready=%b busy=%b done=%b rx=%0d, want 0 0 0 0",
                     tready_u, busy_u, done_u, rx_u);
        end else begin
            n_pass++;
        end
        tvalid = 1'b0;
        start_run(32'd2);
        stim_q = '{16'hACE1, 16'hE270};
        drive_stream(40);
        n_checks++;
        if ({pass_u, done_u, rx_u} !== {2'b11, 32'd2}) begin
            $display("FAIL restart_pass: got pass=%b done=%b rx=%0d, want 1 1 2", pass_u, done_u, rx_u);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic [15:0] x;
        do_reset();
        thr_sel = 1'b0;
        start_run(32'd70000);
        x = SEED_C;
        for (int i = 0; i < 70000; i++) begin
            stim_q.push_back(~x);
            x = lfsr_step(x);
        end
        drive_stream(70100);
        n_checks++;
        if ({err_u, fidx_u, rx_u, pass_u, done_u} !== {16'hFFFF, 32'd0, 32'd70000, 2'b01}) begin
            $display("FAIL saturation: got err=%h fidx=%0d rx=%0d pass=%b done=%b, want FFFF 0 70000 0 1",
                     err_u, fidx_u, rx_u, pass_u, done_u);
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mismatch();
        test_throttle();
        test_zero_words();
        test_reset_mid_run();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_lfsr_checker.md
AXIS_LFSR_CHECKER -- requirements
Module: axis_lfsr_checker

Interface
REQ-001 The block SHALL have parameter SEED, default 16'hACE1, meaning the initial expected word of the check sequence.
REQ-002 The block SHALL have parameter POLY, default 16'hB400, meaning the Galois LFSR tap mask (x^16+x^14+x^13+x^11+1).
REQ-003 The block SHALL have parameter THROTTLE_EN, default 1, meaning tready back-pressure is inserted when set to 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; it is driven from the controller's m_axis_aclk.
REQ-005 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle pulse that begins a check run.
REQ-007 The block SHALL have port word_num, input, 32 bits: number of words to check, sampled on start.
REQ-008 The block SHALL have port s_axis_tvaild, input, 1 bit: upstream data valid, driven by the controller's m_axis_tvaild.
REQ-009 The block SHALL have port s_axis_tready, output, 1 bit: the block accepts data.
REQ-010 The block SHALL have port s_axis_tdata, input, 16 bits: the received word.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in CHECK.
REQ-012 The block SHALL have port done, output, 1 bit: level, high while in DONE.
REQ-013 The block SHALL have port pass, output, 1 bit: valid when done=1; set to 1 iff err_cnt==0.
REQ-014 The block SHALL have port err_cnt, output, 16 bits: mismatch count, saturating.
REQ-015 The block SHALL have port first_err_idx, output, 32 bits: beat index of the first mismatch.
REQ-016 The block SHALL have port rx_cnt, output, 32 bits: number of accepted beats.

Function
REQ-017 The FSM SHALL have exactly three states, IDLE, CHECK and DONE, with IDLE as the reset state.
REQ-018 On start in IDLE or DONE, the block SHALL latch word_num, set expected=SEED, and clear rx_cnt, err_cnt and first_err_idx to 0.
REQ-019 On that same start, the block SHALL enter CHECK if word_num!=0, and otherwise enter DONE directly with pass=1.
REQ-020 The block SHALL ignore start while in CHECK.
REQ-021 A handshake SHALL occur on a rising clk edge where s_axis_tvaild=1 and s_axis_tready=1; the block SHALL take no action on s_axis_tdata without a handshake.
REQ-022 On each handshake, the block SHALL compare s_axis_tdata with expected and increment rx_cnt by 1.
REQ-023 On each handshake, the block SHALL advance expected to (expected>>1) ^ (expected[0] ? POLY : 16'h0).
REQ-024 On a mismatch, err_cnt SHALL increment and hold at 16'hFFFF without wrapping.
REQ-025 On a mismatch while err_cnt==0, first_err_idx SHALL capture the pre-increment rx_cnt value.
REQ-026 The sequence from SEED 16'hACE1 SHALL be ACE1, E270, 7138, 389C, ...
REQ-027 s_axis_tready SHALL be 0 in IDLE and DONE.
REQ-028 In CHECK with THROTTLE_EN=0, s_axis_tready SHALL be 1.
REQ-029 In CHECK with THROTTLE_EN=1, a 2-bit counter SHALL be cleared on entry to CHECK and increment every cycle, and s_axis_tready SHALL be 0 only when the counter equals 3, giving the repeating pattern 1,1,1,0.
REQ-030 s_axis_tready SHALL be a registered output.
REQ-031 The handshake that makes rx_cnt equal the latched word_num SHALL move the FSM to DONE on the same edge, so that done=1 and s_axis_tready=0 in the following cycle.
REQ-032 pass SHALL be registered together with entry to DONE, and SHALL include any mismatch on the final beat.
REQ-033 The block SHALL hold done, pass, err_cnt, first_err_idx and rx_cnt stable in DONE until the next start.
REQ-034 rx_cnt SHALL NOT wrap; word_num SHALL be limited to at most 32'hFFFF_FFFF.

Reset
REQ-035 Asserting rst_n=0 SHALL asynchronously force state=IDLE, expected=SEED, the throttle counter to 0, and all outputs to 0, including s_axis_tready, busy, done, pass, err_cnt, first_err_idx and rx_cnt.
REQ-036 A reset during CHECK SHALL abort the run; the block SHALL NOT accept further beats until a new start following release of rst_n.
REQ-037 Deassertion of rst_n SHALL take effect at the next clk edge.

Verification
REQ-038 The bench SHALL apply start with word_num=4 and THROTTLE_EN=0, then feed ACE1, E270, 7138, 389C back-to-back, and SHALL check rx_cnt=4, err_cnt=0, pass=1, and done=1 one cycle after the 4th beat.
REQ-039 The bench SHALL apply start with word_num=4 and feed ACE1, E270, 0000, 389C, and SHALL check err_cnt=1, first_err_idx=2 and pass=0.
REQ-040 The bench SHALL hold s_axis_tvaild=1 with THROTTLE_EN=1 and word_num=6, and SHALL check the tready pattern 1,1,1,0,1,1,1, exactly 6 handshakes, and the final beat landing on the 7th CHECK cycle.
REQ-041 The bench SHALL apply start with word_num=0 and SHALL check DONE is reached the next cycle with pass=1, rx_cnt=0 and no tready asserted.
REQ-042 The bench SHALL pulse rst_n low after 2 beats of an 8-word run and SHALL check all outputs=0, state IDLE and tready=0; after a new start with word_num=2 and ACE1, E270, it SHALL check pass=1.
REQ-043 The bench SHALL run 70000 words, all wrong, and SHALL check that err_cnt saturates at FFFF, first_err_idx=0 and rx_cnt=70000.
